// File: rtl/cpx_io_pkg.sv
// Shared types and helpers for the CPX return-packet request sequencer.
package cpx_io_pkg;

  localparam int NDEST       = 8;
  localparam int CREDITS_DEF = 2;
  localparam int DEST_W      = $clog2(NDEST);

  typedef logic [NDEST-1:0] dest_vec_t;

  // Turns a core id (or a broadcast flag) into a one-bit-per-core target mask.
  function automatic dest_vec_t dest_decode(input logic [DEST_W-1:0] id, input logic bcast);
    dest_vec_t vec;
    if (bcast) begin
      vec = '1;
    end else begin
      vec = dest_vec_t'(1) << id;
    end
    return vec;
  endfunction

endpackage

// File: rtl/cpx_io_credit.sv
// One per-core credit counter mirroring the free slots of a CPX arbiter queue.
module cpx_io_credit #(
  parameter int CREDITS = 2
) (
  input  logic rclk,
  input  logic reset,
  input  logic dec,
  input  logic inc,
  output logic has_credit,
  output logic full,
  output logic err_pulse
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [CW-1:0] cnt;

  // Issue spends a credit, grant returns one; both together cancel, and a grant at the ceiling saturates.
  always_ff @(posedge rclk) begin
    if (reset) begin
      cnt <= CMAX;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else if (inc && !dec && cnt != CMAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Status flags derived from the current count; a grant with no room is an error.
  always_comb begin
    has_credit = (cnt != '0);
    full       = (cnt == CMAX);
    err_pulse  = inc & ~dec & (cnt == CMAX);
  end

endmodule

// File: rtl/cpx_io_req_ctl.sv
// Descriptor FIFO plus per-core credit gating that issues CPX request pulses in strict order.
module cpx_io_req_ctl
  import cpx_io_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int CREDITS = CREDITS_DEF
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic              pkt_vld,
  input  logic [DEST_W-1:0] pkt_dest,
  input  logic              pkt_bcast,
  output logic              pkt_rdy,
  input  logic [NDEST-1:0]  cpx_io_grant_ca,
  output logic [NDEST-1:0]  io_cpx_req_cq,
  output logic              pkt_issue,
  output logic              credit_err,
  output logic              busy
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  dest_vec_t       mem [QDEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            issue_ok;
  dest_vec_t       head_vec;
  logic [NDEST-1:0] has_credit;
  logic [NDEST-1:0] credit_full;
  logic [NDEST-1:0] err_pulse;

  // FIFO status, admission and the atomic all-targets-have-credit issue decision.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pkt_rdy  = ~full;
    push     = pkt_vld & ~full;
    head_vec = mem[rd_ptr[AW-1:0]];
    issue_ok = ~empty & ((head_vec & ~has_credit) == '0);
    busy     = ~empty | ~(&credit_full);
  end

  // Descriptor storage; contents need no reset because the pointers define validity.
  always_ff @(posedge rclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= dest_decode(pkt_dest, pkt_bcast);
    end
  end

  // Pointer update; a pop frees a slot only for the following cycle since pkt_rdy looks at state.
  always_ff @(posedge rclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (issue_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Registered request pulse and issue strobe, plus the sticky credit error flag.
  always_ff @(posedge rclk) begin
    if (reset) begin
      io_cpx_req_cq <= '0;
      pkt_issue     <= 1'b0;
      credit_err    <= 1'b0;
    end else begin
      io_cpx_req_cq <= issue_ok ? head_vec : '0;
      pkt_issue     <= issue_ok;
      if (|err_pulse) begin
        credit_err <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NDEST; i++) begin : g_credit
    cpx_io_credit #(
      .CREDITS(CREDITS)
    ) u_credit (
      .rclk       (rclk),
      .reset      (reset),
      .dec        (issue_ok & head_vec[i]),
      .inc        (cpx_io_grant_ca[i]),
      .has_credit (has_credit[i]),
      .full       (credit_full[i]),
      .err_pulse  (err_pulse[i])
    );
  end

endmodule
